// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin share of one 18x17 signed*unsigned multiplier among NUM_REQ requesters
// Ports:
//   ap_clk, ap_rst_n               clock, async active-low reset
//   req_valid/req_ready            per-requester handshake (ready is one-hot or zero)
//   req_din0/req_din1              packed operands, requester i at [i*W +: W]
//   out_valid/out_ready            result handshake
//   out_id/out_dout                winning requester index and truncated product
//   op_count                       completed output transfers, wrapping
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DIN0_W  = 18,
  parameter int DIN1_W  = 17,
  parameter int DOUT_W  = 24,
  parameter int CNT_W   = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DIN0_W-1:0]   req_din0,
  input  logic [NUM_REQ*DIN1_W-1:0]   req_din1,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ID_W-1:0]             out_id,
  output logic [DOUT_W-1:0]           out_dout,
  output logic [CNT_W-1:0]            op_count
);
  localparam int P_W = DIN0_W + DIN1_W + 1;
  logic [ID_W-1:0]          rr_ptr_q;
  logic [ID_W-1:0]          gnt_id;
  logic [ID_W-1:0]          idx;
  logic                     found;
  logic                     slot_free;
  logic                     grant;
  logic [DIN0_W-1:0]        din0;
  logic [DIN1_W-1:0]        din1;
  logic signed [P_W-1:0]    prod;
  logic                     out_valid_q, out_valid_d;
  logic [ID_W-1:0]          out_id_q, out_id_d;
  logic [DOUT_W-1:0]        out_dout_q, out_dout_d;
  logic [CNT_W-1:0]         op_count_q, op_count_d;
  logic [ID_W-1:0]          rr_ptr_d;
  // Walk from farthest to nearest so the nearest valid index after rr_ptr wins.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign slot_free = !out_valid_q || out_ready;
  assign grant     = found && slot_free;
  assign req_ready = grant ? (NUM_REQ'(1) << gnt_id) : '0;
  assign din0      = req_din0[gnt_id*DIN0_W +: DIN0_W];
  assign din1      = req_din1[gnt_id*DIN1_W +: DIN1_W];
  // Zero-extend the unsigned operand so the product is computed fully signed.
  assign prod      = $signed(din0) * $signed({1'b0, din1});
  always_comb begin
    out_valid_d = grant ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_id_d    = grant ? gnt_id : out_id_q;
    out_dout_d  = grant ? prod[DOUT_W-1:0] : out_dout_q;
    rr_ptr_d    = grant ? gnt_id : rr_ptr_q;
    op_count_d  = op_count_q + CNT_W'(out_valid_q && out_ready);
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_dout_q  <= '0;
      op_count_q  <= '0;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_dout_q  <= out_dout_d;
      op_count_q  <= op_count_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_dout  = out_dout_q;
  assign op_count  = op_count_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;
  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [71:0]   req_din0;
  logic [67:0]   req_din1;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_id;
  logic [23:0]   out_dout;
  logic [15:0]   op_count;
  int n_vec = 0;
  int n_err = 0;
  mul_share_arbiter dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_dout(out_dout), .op_count(op_count)
  );
  always #5 ap_clk = ~ap_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask
  task automatic set_op(input int i, input logic [17:0] d0, input logic [16:0] d1);
    req_din0[i*18 +: 18] = d0;
    req_din1[i*17 +: 17] = d1;
  endtask
  function automatic logic [23:0] rr_exp(input int i);
    return 24'((-(i + 1)) * (100 + i));
  endfunction
  initial begin
    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_din0  = '0;
    req_din1  = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_id",    32'(out_id),    32'd0);
    chk("rst_dout",  32'(out_dout),  32'd0);
    chk("rst_cnt",   32'(op_count),  32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    ap_rst_n = 1'b1;
    step();
    set_op(0, 18'h3FFFD, 17'd5);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_id",    32'(out_id),    32'd0);
    chk("single_dout",  32'(out_dout),  32'hFFFFF1);
    req_valid = '0;
    #1;
    chk("idle_ready", 32'(req_ready), 32'd0);
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("single_cnt",  32'(op_count),  32'd1);
    ap_rst_n = 1'b0;
    #1;
    ap_rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) set_op(i, 18'(-(i + 1)), 17'(100 + i));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      step();
      chk("rr_id",   32'(out_id),   32'(k % 4));
      chk("rr_dout", 32'(out_dout), 32'(rr_exp(k % 4)));
    end
    chk("rr_cnt", 32'(op_count), 32'd7);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'd0);
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_id",    32'(out_id),    32'd3);
      chk("bp_dout",  32'(out_dout),  32'(rr_exp(3)));
    end
    chk("bp_cnt", 32'(op_count), 32'd7);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h1);
    step();
    chk("bp_release_id",   32'(out_id),   32'd0);
    chk("bp_release_dout", 32'(out_dout), 32'(rr_exp(0)));
    chk("bp_release_cnt",  32'(op_count), 32'd8);
    req_valid = '0;
    step();
    chk("rr_drain_valid", 32'(out_valid), 32'd0);
    chk("rr_drain_cnt",   32'(op_count),  32'd9);
    set_op(2, 18'h1FFFF, 17'h1FFFF);
    req_valid = 4'b0100;
    #1;
    chk("trunc_ready", 32'(req_ready), 32'h4);
    step();
    chk("trunc_id",   32'(out_id),   32'd2);
    chk("trunc_dout", 32'(out_dout), 32'hFC0001);
    req_valid = '0;
    step();
    chk("trunc_cnt", 32'(op_count), 32'd10);
    set_op(0, 18'd7, 17'd3);
    set_op(2, 18'h3FFFE, 17'd9);
    set_op(3, 18'd1, 17'd1);
    req_valid = 4'b1000;
    step();
    chk("sparse_pre_id", 32'(out_id), 32'd3);
    req_valid = 4'b0101;
    #1;
    chk("sparse_ready0", 32'(req_ready), 32'h1);
    step();
    chk("sparse_id0",   32'(out_id),   32'd0);
    chk("sparse_dout0", 32'(out_dout), 32'd21);
    #1;
    chk("sparse_ready1", 32'(req_ready), 32'h4);
    step();
    chk("sparse_id1",   32'(out_id),   32'd2);
    chk("sparse_dout1", 32'(out_dout), 32'hFFFFEE);
    #1;
    chk("sparse_ready2", 32'(req_ready), 32'h1);
    step();
    chk("sparse_id2", 32'(out_id), 32'd0);
    req_valid = '0;
    step();
    chk("sparse_cnt", 32'(op_count), 32'd14);
    req_valid = 4'b0001;
    step();
    chk("mid_valid_pre", 32'(out_valid), 32'd1);
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_dout",  32'(out_dout),  32'd0);
    chk("mid_rst_id",    32'(out_id),    32'd0);
    chk("mid_rst_cnt",   32'(op_count),  32'd0);
    req_valid = '0;
    step();
    ap_rst_n = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    req_valid = 4'b0001;
    repeat (65536) step();
    chk("wrap_max", 32'(op_count), 32'hFFFF);
    step();
    chk("wrap_zero", 32'(op_count), 32'd0);
    req_valid = '0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
